// File: rtl/atm_fsm_if.sv
// Front-end bus of the ATM controller: menu/status inputs and the state outputs.
interface atm_fsm_if;
   logic [1:0]  usr_input;
   logic [3:0]  status_code;
   logic [15:0] current_state;
   logic [3:0]  input_style_out;
   logic [15:0] state_led;

   modport master (
      output usr_input, status_code,
      input  current_state, input_style_out, state_led
   );

   modport slave (
      input  usr_input, status_code,
      output current_state, input_style_out, state_led
   );
endinterface

// File: rtl/atm_fsm.sv
// ATM session controller: edge-detected status/selection events drive a 16-state Moore FSM.
// Define ATM_FSM_TIMEOUT_EN to add the idle timeout that returns to IDLE after TIMEOUT_CYCLES.
module atm_fsm #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   atm_fsm_if.slave   bus
);

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_ACC_CHECK  = 4'd1,
      S_PIN_INPUT  = 4'd2,
      S_MENU       = 4'd3,
      S_BALANCE    = 4'd4,
      S_CONV_INPUT = 4'd5,
      S_CONV_CHECK = 4'd6,
      S_CONV_DONE  = 4'd7,
      S_WD_INPUT   = 4'd8,
      S_WD_CHECK   = 4'd9,
      S_WD_DONE    = 4'd10,
      S_TR_ACC     = 4'd11,
      S_TR_AMT     = 4'd12,
      S_TR_CHECK   = 4'd13,
      S_TR_DONE    = 4'd14,
      S_FAIL       = 4'd15
   } state_t;

   localparam logic [3:0] ACC_FOUND      = 4'd1;
   localparam logic [3:0] ACC_NOT_FOUND  = 4'd2;
   localparam logic [3:0] PIN_CORRECT    = 4'd3;
   localparam logic [3:0] PIN_INCORRECT  = 4'd4;
   localparam logic [3:0] AMT_VALID      = 4'd5;
   localparam logic [3:0] AMT_INVALID    = 4'd6;
   localparam logic [3:0] EXIT           = 4'd7;
   localparam logic [3:0] INPUT_COMPLETE = 4'd8;

   if (TIMEOUT_CYCLES == 0) begin : g_cfg_check
      $error("atm_fsm: TIMEOUT_CYCLES must be nonzero");
   end

   state_t      state, state_nx;
   logic [3:0]  status_q;
   logic [1:0]  usr_q;
   logic [15:0] led_q, led_nx;
   logic [3:0]  style_q, style_nx;
   logic [3:0]  code;
   logic        status_ev, sel_ev, timeout;

   assign code      = bus.status_code;
   assign status_ev = (code != '0) && (code != status_q);
   assign sel_ev    = (bus.usr_input != usr_q);

`ifdef ATM_FSM_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] idle_cnt;

   // The cycle that would be the TIMEOUT_CYCLES-th event-free one forces IDLE.
   assign timeout = !(status_ev || sel_ev) && (state != S_IDLE) &&
                    (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         idle_cnt <= '0;
      else if (status_ev || sel_ev || state == S_IDLE || timeout)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      if (status_ev && code == EXIT) begin
         if (state == S_IDLE || state == S_ACC_CHECK || state == S_PIN_INPUT || state == S_MENU)
            state_nx = S_IDLE;
         else
            state_nx = S_MENU;
      end else begin
         unique case (state)
            S_IDLE:
               if (status_ev && code == INPUT_COMPLETE) state_nx = S_ACC_CHECK;
            S_ACC_CHECK: begin
               if (status_ev && code == ACC_FOUND)     state_nx = S_PIN_INPUT;
               if (status_ev && code == ACC_NOT_FOUND) state_nx = S_IDLE;
            end
            S_PIN_INPUT: begin
               if (status_ev && code == PIN_CORRECT)   state_nx = S_MENU;
               if (status_ev && code == PIN_INCORRECT) state_nx = S_IDLE;
            end
            S_MENU:
               if (sel_ev || (status_ev && code == INPUT_COMPLETE)) begin
                  unique case (bus.usr_input)
                     2'd0: state_nx = S_BALANCE;
                     2'd1: state_nx = S_CONV_INPUT;
                     2'd2: state_nx = S_WD_INPUT;
                     2'd3: state_nx = S_TR_ACC;
                  endcase
               end
            S_CONV_INPUT:
               if (status_ev && code == INPUT_COMPLETE) state_nx = S_CONV_CHECK;
            S_WD_INPUT:
               if (status_ev && code == INPUT_COMPLETE) state_nx = S_WD_CHECK;
            S_TR_AMT:
               if (status_ev && code == INPUT_COMPLETE) state_nx = S_TR_CHECK;
            S_CONV_CHECK: begin
               if (status_ev && code == AMT_VALID)   state_nx = S_CONV_DONE;
               if (status_ev && code == AMT_INVALID) state_nx = S_FAIL;
            end
            S_WD_CHECK: begin
               if (status_ev && code == AMT_VALID)   state_nx = S_WD_DONE;
               if (status_ev && code == AMT_INVALID) state_nx = S_FAIL;
            end
            S_TR_CHECK: begin
               if (status_ev && code == AMT_VALID)   state_nx = S_TR_DONE;
               if (status_ev && code == AMT_INVALID) state_nx = S_FAIL;
            end
            S_TR_ACC: begin
               if (status_ev && code == ACC_FOUND)     state_nx = S_TR_AMT;
               if (status_ev && code == ACC_NOT_FOUND) state_nx = S_FAIL;
            end
            default: state_nx = state;
         endcase
      end
      if (timeout)
         state_nx = S_IDLE;
   end

   // Moore outputs are decoded from the next state so they register alongside it.
   always_comb begin
      led_nx = 16'd1 << state_nx;
      unique case (state_nx)
         S_IDLE:                           style_nx = 4'd1;
         S_PIN_INPUT:                      style_nx = 4'd2;
         S_MENU:                           style_nx = 4'd3;
         S_CONV_INPUT, S_WD_INPUT, S_TR_AMT: style_nx = 4'd4;
         S_TR_ACC:                         style_nx = 4'd5;
         default:                          style_nx = 4'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         status_q <= '0;
         usr_q    <= '0;
         led_q    <= 16'h0001;
         style_q  <= 4'd1;
      end else begin
         state    <= state_nx;
         status_q <= code;
         usr_q    <= bus.usr_input;
         led_q    <= led_nx;
         style_q  <= style_nx;
      end
   end

   assign bus.current_state   = {12'd0, state};
   assign bus.state_led       = led_q;
   assign bus.input_style_out = style_q;

endmodule

// File: tb/tb_atm_fsm.sv
// Directed self-checking bench for atm_fsm; timeout checks apply when ATM_FSM_TIMEOUT_EN is defined.
module tb_atm_fsm;

   logic clk;
   logic rst_n;
   int unsigned errors;
   int unsigned checks;

   atm_fsm_if bus ();

   atm_fsm #(.TIMEOUT_CYCLES(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   // Drive inputs on a falling edge, then let the event register and settle.
   task automatic apply(input logic [3:0] code, input logic [1:0] sel);
      @(negedge clk);
      bus.status_code = code;
      bus.usr_input   = sel;
      repeat (3) @(negedge clk);
   endtask

   task automatic st(input logic [3:0] code);
      apply(code, bus.usr_input);
   endtask

   task automatic sel(input logic [1:0] u);
      apply(bus.status_code, u);
   endtask

   task automatic login;
      st(4'd8);
      check("login_acc", bus.current_state, 16'd1);
      st(4'd1);
      check("login_pin", bus.current_state, 16'd2);
      st(4'd3);
      check("login_menu", bus.current_state, 16'd3);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      bus.status_code = 4'd0;
      bus.usr_input   = 2'd0;
      #12;
      check("rst_state", bus.current_state, 16'd0);
      check("rst_led", bus.state_led, 16'h0001);
      check("rst_style", {12'd0, bus.input_style_out}, 16'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_idle", bus.current_state, 16'd0);

      // Account not found
      st(4'd8);
      check("acc_check", bus.current_state, 16'd1);
      check("acc_check_led", bus.state_led, 16'h0002);
      st(4'd2);
      check("acc_nf_idle", bus.current_state, 16'd0);
      check("acc_nf_led", bus.state_led, 16'h0001);

      // Wrong PIN
      st(4'd8);
      check("pin_acc", bus.current_state, 16'd1);
      st(4'd1);
      check("pin_state", bus.current_state, 16'd2);
      check("pin_style", {12'd0, bus.input_style_out}, 16'd2);
      st(4'd4);
      check("pin_bad_idle", bus.current_state, 16'd0);

      // Conversion path
      login();
      check("menu_style", {12'd0, bus.input_style_out}, 16'd3);
      sel(2'd1);
      check("conv_input", bus.current_state, 16'd5);
      check("conv_style", {12'd0, bus.input_style_out}, 16'd4);
      st(4'd8);
      check("conv_check", bus.current_state, 16'd6);
      st(4'd5);
      check("conv_done", bus.current_state, 16'd7);
      check("conv_done_style", {12'd0, bus.input_style_out}, 16'd0);
      st(4'd7);
      check("conv_exit_menu", bus.current_state, 16'd3);
      repeat (3) @(negedge clk);
      check("exit_held_menu", bus.current_state, 16'd3);

      // Withdraw with invalid amount
      sel(2'd2);
      check("wd_input", bus.current_state, 16'd8);
      st(4'd8);
      check("wd_check", bus.current_state, 16'd9);
      st(4'd6);
      check("wd_fail", bus.current_state, 16'd15);
      check("wd_fail_led", bus.state_led, 16'h8000);
      st(4'd7);
      check("wd_exit_menu", bus.current_state, 16'd3);

      // Transfer to unknown account, then exit twice
      sel(2'd3);
      check("tr_acc", bus.current_state, 16'd11);
      check("tr_acc_style", {12'd0, bus.input_style_out}, 16'd5);
      st(4'd2);
      check("tr_fail", bus.current_state, 16'd15);
      st(4'd7);
      check("tr_exit_menu", bus.current_state, 16'd3);
      st(4'd0);
      check("menu_noop", bus.current_state, 16'd3);
      st(4'd7);
      check("menu_exit_idle", bus.current_state, 16'd0);

      // EXIT beats a simultaneous selection change in MENU
      login();
      st(4'd0);
      apply(4'd7, 2'd0);
      check("exit_priority", bus.current_state, 16'd0);

      // Idle persistence / timeout
      login();
`ifdef ATM_FSM_TIMEOUT_EN
      repeat (10) @(negedge clk);
      check("timeout_idle", bus.current_state, 16'd0);
      login();
`else
      repeat (40) @(negedge clk);
      check("menu_persist", bus.current_state, 16'd3);
`endif

      // Asynchronous reset mid-withdraw
      sel(2'd2);
      check("wd_before_rst", bus.current_state, 16'd8);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_state", bus.current_state, 16'd0);
      check("async_rst_led", bus.state_led, 16'h0001);
      check("async_rst_style", {12'd0, bus.input_style_out}, 16'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("after_rst_idle", bus.current_state, 16'd0);
      st(4'd8);
      check("after_rst_event", bus.current_state, 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
